// File: rtl/grf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: controller state
// encoding and default sizing.
package grf_write_arbiter_pkg;

  localparam int unsigned DefaultDepth       = 2;
  localparam int unsigned DefaultStarveLimit = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StStarve = 2'd2
  } arb_state_e;

endpackage

// File: rtl/grf_write_arbiter_aux_write_fifo.sv
// In-order buffer of auxiliary register writes. Entries are kept compacted at
// index 0 so killed entries vanish at the edge instead of occupying a head slot.
module aux_write_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [4:0]  push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        kill_en,
  input  logic [4:0]  kill_addr,
  output logic        head_valid,
  output logic [4:0]  head_addr,
  output logic [31:0] head_data,
  output logic        head_kill,
  output logic        full,
  output logic        empty_next,
  output logic [31:0] pending_mask
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, kill;
  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [IdxW:0]    n;
  logic             push_keep;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = kill_en && valid_q[i] && (addr_q[i] == kill_addr);
    end
  end

  // Writes to r0 and writes overwritten by a same-cycle write-back are dropped.
  assign push_keep = push && !full && (push_addr != 5'd0) &&
                     !(kill_en && (push_addr == kill_addr));

  always_comb begin
    valid_d = '0;
    n       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = '0;
      data_d[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill[i] && !(pop && (i == 0))) begin
        valid_d[n[IdxW-1:0]] = 1'b1;
        addr_d[n[IdxW-1:0]]  = addr_q[i];
        data_d[n[IdxW-1:0]]  = data_q[i];
        n                    = n + (IdxW+1)'(1);
      end
    end
    if (push_keep) begin
      valid_d[n[IdxW-1:0]] = 1'b1;
      addr_d[n[IdxW-1:0]]  = push_addr;
      data_d[n[IdxW-1:0]]  = push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending_mask[addr_q[i]] = 1'b1;
    end
  end

  assign head_valid = valid_q[0];
  assign head_addr  = addr_q[0];
  assign head_data  = data_q[0];
  assign head_kill  = kill[0];
  assign full       = valid_q[DEPTH-1];
  assign empty_next = !valid_d[0];

endmodule

// File: rtl/grf_write_arbiter.sv
// Merges the write-back port with buffered multi-cycle results into the single
// register-file write port; write-back always wins, a starved head asks for a stall.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = DefaultDepth,
  parameter int unsigned STARVE_LIMIT = DefaultStarveLimit
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        grf_we,
  output logic [4:0]  grf_addr,
  output logic [31:0] grf_data,
  output logic        stall_req,
  output logic [31:0] pending_mask
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  arb_state_e  state_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        wb_act, push, pop, blocked;
  logic        head_valid, head_kill, full, empty_next;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign wb_act    = reset_n && wb_we && (wb_addr != 5'd0);
  assign aux_ready = reset_n && !full;
  assign push      = aux_valid && aux_ready;
  assign pop       = !wb_act && head_valid;
  assign blocked   = head_valid && wb_act && !head_kill;

  aux_write_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (push),
    .push_addr    (aux_addr),
    .push_data    (aux_data),
    .pop          (pop),
    .kill_en      (wb_act),
    .kill_addr    (wb_addr),
    .head_valid   (head_valid),
    .head_addr    (head_addr),
    .head_data    (head_data),
    .head_kill    (head_kill),
    .full         (full),
    .empty_next   (empty_next),
    .pending_mask (pending_mask)
  );

  always_comb begin
    grf_we   = 1'b0;
    grf_addr = '0;
    grf_data = '0;
    if (wb_act) begin
      grf_we   = 1'b1;
      grf_addr = wb_addr;
      grf_data = wb_data;
    end else if (head_valid) begin
      grf_we   = 1'b1;
      grf_addr = head_addr;
      grf_data = head_data;
    end
  end

  // Counts cycles the current head has been blocked; restarts with each new head.
  always_comb begin
    if (pop || head_kill || !head_valid) begin
      cnt_d = '0;
    end else if (blocked && (cnt_q != CntW'(STARVE_LIMIT))) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      stall_req <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        StIdle: begin
          if (!empty_next) state_q <= StWait;
        end
        StWait: begin
          if (empty_next) begin
            state_q <= StIdle;
          end else if (cnt_d == CntW'(STARVE_LIMIT)) begin
            state_q   <= StStarve;
            stall_req <= 1'b1;
          end
        end
        StStarve: begin
          if (pop || head_kill) begin
            stall_req <= 1'b0;
            state_q   <= empty_next ? StIdle : StWait;
          end
        end
        default: begin
          state_q   <= StIdle;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench for grf_write_arbiter: write-back checks are immediate,
// auxiliary writes are checked against a queue of expected results.
module tb_grf_write_arbiter;
  import grf_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic        stall_req;
  logic [31:0] pending_mask;

  logic [4:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  grf_write_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .aux_valid    (aux_valid),
    .aux_ready    (aux_ready),
    .aux_addr     (aux_addr),
    .aux_data     (aux_data),
    .grf_we       (grf_we),
    .grf_addr     (grf_addr),
    .grf_data     (grf_data),
    .stall_req    (stall_req),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  task automatic drive_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
    aux_valid = v; aux_addr = a; aux_data = d;
  endtask

  task automatic expect_aux(input logic [4:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Sample mid-cycle and check whatever the write port is doing.
  task automatic half();
    logic [4:0]  ea;
    logic [31:0] ed;
    @(negedge clk);
    if (reset_n && wb_we && (wb_addr != 5'd0)) begin
      check("wb_we", 32'(grf_we), 32'd1);
      check("wb_addr", 32'(grf_addr), 32'(wb_addr));
      check("wb_data", grf_data, wb_data);
    end else if (grf_we) begin
      if (exp_addr_q.size() == 0) begin
        check("spurious_write", 32'(grf_we), 32'd0);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("aux_addr", 32'(grf_addr), 32'(ea));
        check("aux_data", grf_data, ed);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_aux(1'b0, 5'd0, 32'd0);

    // Reset values
    half();
    check("rst_aux_ready", 32'(aux_ready), 32'd0);
    check("rst_grf_we", 32'(grf_we), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_pending", pending_mask, 32'd0);
    adv();
    reset_n = 1'b1;
    half();
    check("post_rst_ready", 32'(aux_ready), 32'd1);
    check("idle_grf_we", 32'(grf_we), 32'd0);
    check("idle_grf_addr", 32'(grf_addr), 32'd0);
    check("idle_grf_data", grf_data, 32'd0);
    adv();

    // WB-only
    drive_wb(1'b1, 5'd5, 32'h1234);
    half();
    check("wb_only_stall", 32'(stall_req), 32'd0);
    adv();
    drive_wb(1'b0, 5'd0, 32'd0);

    // Aux drain
    drive_aux(1'b1, 5'd9, 32'hCAFE);
    expect_aux(5'd9, 32'hCAFE);
    half();
    check("drain_incoming_mask", pending_mask, 32'd0);
    check("drain_no_early_write", 32'(grf_we), 32'd0);
    adv();
    drive_aux(1'b0, 5'd0, 32'd0);
    half();
    check("drain_mask_r9", pending_mask, 32'h0000_0200);
    adv();
    half();
    check("drain_mask_clear", pending_mask, 32'd0);
    check("drain_done_we", 32'(grf_we), 32'd0);
    adv();

    // Starvation
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_aux(1'b1, 5'd11, 32'hBEEF);
    expect_aux(5'd11, 32'hBEEF);
    half();
    adv();
    drive_aux(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      half();
      check("starve_no_stall_yet", 32'(stall_req), 32'd0);
      adv();
    end
    half();
    check("starve_stall_up", 32'(stall_req), 32'd1);
    check("starve_mask_r11", pending_mask, 32'h0000_0800);
    adv();
    drive_wb(1'b0, 5'd0, 32'd0);
    half();
    check("starve_stall_held", 32'(stall_req), 32'd1);
    adv();
    half();
    check("starve_stall_down", 32'(stall_req), 32'd0);
    check("starve_state_idle", 32'(dut.state_q), 32'(StIdle));
    adv();

    // WAW kill
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_aux(1'b1, 5'd7, 32'h7777);
    half();
    adv();
    drive_aux(1'b0, 5'd0, 32'd0);
    drive_wb(1'b1, 5'd7, 32'h70);
    half();
    check("waw_mask_r7", pending_mask, 32'h0000_0080);
    adv();
    drive_wb(1'b0, 5'd0, 32'd0);
    half();
    check("waw_no_aux_write", 32'(grf_we), 32'd0);
    check("waw_mask_clear", pending_mask, 32'd0);
    adv();

    // Full / backpressure
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_aux(1'b1, 5'd1, 32'h11);
    expect_aux(5'd1, 32'h11);
    half();
    check("full_ready_0", 32'(aux_ready), 32'd1);
    adv();
    drive_aux(1'b1, 5'd2, 32'h22);
    expect_aux(5'd2, 32'h22);
    half();
    check("full_ready_1", 32'(aux_ready), 32'd1);
    adv();
    drive_aux(1'b1, 5'd4, 32'h44);
    expect_aux(5'd4, 32'h44);
    half();
    check("full_ready_low", 32'(aux_ready), 32'd0);
    check("full_mask", pending_mask, 32'h0000_0006);
    adv();
    half();
    check("full_held_off", 32'(aux_ready), 32'd0);
    check("full_mask_held", pending_mask, 32'h0000_0006);
    adv();
    drive_wb(1'b0, 5'd0, 32'd0);
    half();
    check("full_no_accept_on_pop", 32'(aux_ready), 32'd0);
    adv();
    half();
    check("full_ready_back", 32'(aux_ready), 32'd1);
    adv();
    drive_aux(1'b0, 5'd0, 32'd0);
    half();
    adv();
    half();
    check("full_drained_we", 32'(grf_we), 32'd0);
    check("full_drained_ready", 32'(aux_ready), 32'd1);
    adv();

    // Reset mid-drain
    drive_wb(1'b1, 5'd3, 32'h33);
    drive_aux(1'b1, 5'd20, 32'h2020);
    half();
    adv();
    drive_aux(1'b1, 5'd21, 32'h2121);
    half();
    adv();
    drive_aux(1'b0, 5'd0, 32'd0);
    half();
    check("mid_mask_before_rst", pending_mask, 32'h0030_0000);
    adv();
    reset_n = 1'b0;
    half();
    check("mid_rst_grf_we", 32'(grf_we), 32'd0);
    check("mid_rst_pending", pending_mask, 32'd0);
    check("mid_rst_ready", 32'(aux_ready), 32'd0);
    check("mid_rst_stall", 32'(stall_req), 32'd0);
    adv();
    drive_wb(1'b0, 5'd0, 32'd0);
    reset_n = 1'b1;
    half();
    check("mid_rel_grf_we", 32'(grf_we), 32'd0);
    check("mid_rel_pending", pending_mask, 32'd0);
    check("mid_rel_ready", 32'(aux_ready), 32'd1);
    check("mid_rel_state", 32'(dut.state_q), 32'(StIdle));
    adv();
    half();
    check("mid_rel_no_write", 32'(grf_we), 32'd0);
    adv();

    check("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
